// File: rtl/sync_pkg.sv
// Shared types, default sizes and index helper for the tile synchroniser.
package sync_pkg;

  localparam int unsigned SYNC_DATA_W = 16;
  localparam int unsigned SYNC_DIM    = 3;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } sync_state_t;

  // Linear tile index for (row, col), optionally transposed.
  function automatic int unsigned tr_idx(input int unsigned row,
                                         input int unsigned col,
                                         input logic        trans,
                                         input int unsigned dim);
    return trans ? (col * dim + row) : (row * dim + col);
  endfunction

endpackage

// File: rtl/sync_tile_bank.sv
// One ping-pong bank: A/B element storage, write port, indexed combinational
// read and the per-tile B-transpose flag.
module sync_tile_bank
  import sync_pkg::*;
#(
  parameter int unsigned DATA_W = SYNC_DATA_W,
  parameter int unsigned DIM    = SYNC_DIM
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(DIM*DIM)-1:0]    waddr_i,
  input  logic [DATA_W-1:0]             wa_i,
  input  logic [DATA_W-1:0]             wb_i,
  input  logic                          tflag_we_i,
  input  logic                          tflag_i,
  input  logic [$clog2(DIM)-1:0]        rrow_i,
  input  logic [$clog2(DIM)-1:0]        rcol_i,
  output logic [DATA_W-1:0]             rd_a_c,
  output logic [DATA_W-1:0]             rd_b_c
);

  localparam int unsigned N     = DIM * DIM;
  localparam int unsigned PTR_W = $clog2(N);

  logic [DATA_W-1:0] mem_a_q [N];
  logic [DATA_W-1:0] mem_b_q [N];
  logic              tflag_q;
  logic [PTR_W-1:0]  a_idx;
  logic [PTR_W-1:0]  b_idx;

  // Storage is intentionally not reset; full flags in the top qualify it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_a_q[waddr_i] <= wa_i;
      mem_b_q[waddr_i] <= wb_i;
    end
    if (tflag_we_i) begin
      tflag_q <= tflag_i;
    end
  end

  assign a_idx  = PTR_W'(tr_idx(32'(rrow_i), 32'(rcol_i), 1'b0, DIM));
  assign b_idx  = PTR_W'(tr_idx(32'(rrow_i), 32'(rcol_i), tflag_q, DIM));
  assign rd_a_c = mem_a_q[a_idx];
  assign rd_b_c = mem_b_q[b_idx];

endmodule

// File: rtl/sync_tile_buf.sv
// Double-buffered DIM x DIM tile synchroniser: fills one bank while the other
// drains, replaying B straight or transposed per tile.
module sync_tile_buf
  import sync_pkg::*;
#(
  parameter int unsigned DATA_W = SYNC_DATA_W,
  parameter int unsigned DIM    = SYNC_DIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic              trans_b,
  output logic              wr_rdy,
  input  logic              rd,
  output logic              rd_rdy,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b,
  output logic              dout_vld,
  output logic              tile_last,
  output logic              rdy_sy
);

  localparam int unsigned N     = DIM * DIM;
  localparam int unsigned PTR_W = $clog2(N);
  localparam int unsigned RC_W  = $clog2(DIM);

  sync_state_t       state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [RC_W-1:0]   rrow_q, rrow_d;
  logic [RC_W-1:0]   rcol_q, rcol_d;
  logic              wr_rdy_q, wr_rdy_d;
  logic              rd_rdy_q, rd_rdy_d;
  logic              rdy_sy_q, rdy_sy_d;
  logic              dout_vld_q, dout_vld_d;
  logic              tile_last_q, tile_last_d;
  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;

  logic              wr_acc, rd_acc, rd_last;
  logic [1:0]        bank_we, bank_tflag_we;
  logic [DATA_W-1:0] bank_a [2];
  logic [DATA_W-1:0] bank_b [2];

  assign wr_acc  = wr && wr_rdy_q;
  assign rd_acc  = rd && rd_rdy_q;
  assign rd_last = (rrow_q == RC_W'(DIM - 1)) && (rcol_q == RC_W'(DIM - 1));

  for (genvar g = 0; g < 2; g++) begin : g_bank
    sync_tile_bank #(.DATA_W(DATA_W), .DIM(DIM)) u_bank (
      .clk       (clk),
      .we_i      (bank_we[g]),
      .waddr_i   (wptr_q),
      .wa_i      (din_a),
      .wb_i      (din_b),
      .tflag_we_i(bank_tflag_we[g]),
      .tflag_i   (trans_b),
      .rrow_i    (rrow_q),
      .rcol_i    (rcol_q),
      .rd_a_c    (bank_a[g]),
      .rd_b_c    (bank_b[g])
    );
  end

  // Control FSM next state; a partial tile keeps the block in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = WARM;
      WARM:    state_d = RUN;
      RUN:     if (!en && (full_q == 2'b00) && (wptr_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fill/drain pointers, bank flags and registered outputs.
  always_comb begin
    full_d        = full_q;
    wbank_d       = wbank_q;
    rbank_d       = rbank_q;
    wptr_d        = wptr_q;
    rrow_d        = rrow_q;
    rcol_d        = rcol_q;
    bank_we       = '0;
    bank_tflag_we = '0;
    dout_a_d      = dout_a_q;
    dout_b_d      = dout_b_q;
    dout_vld_d    = rd_acc;
    tile_last_d   = rd_acc && rd_last;

    bank_we[wbank_q]       = wr_acc;
    bank_tflag_we[wbank_q] = wr_acc && (wptr_q == '0);

    if (wr_acc) begin
      if (wptr_q == PTR_W'(N - 1)) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
        wptr_d          = '0;
      end else begin
        wptr_d = wptr_q + PTR_W'(1);
      end
    end

    if (rd_acc) begin
      dout_a_d = bank_a[rbank_q];
      dout_b_d = bank_b[rbank_q];
      if (rd_last) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
        rrow_d          = '0;
        rcol_d          = '0;
      end else if (rcol_q == RC_W'(DIM - 1)) begin
        rcol_d = '0;
        rrow_d = rrow_q + RC_W'(1);
      end else begin
        rcol_d = rcol_q + RC_W'(1);
      end
    end

    // Ready flags reflect the post-edge state so they are visible one cycle on.
    rdy_sy_d = (state_d == RUN);
    wr_rdy_d = rdy_sy_d && en && !full_d[wbank_d];
    rd_rdy_d = rdy_sy_d && full_d[rbank_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      full_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wptr_q      <= '0;
      rrow_q      <= '0;
      rcol_q      <= '0;
      wr_rdy_q    <= 1'b0;
      rd_rdy_q    <= 1'b0;
      rdy_sy_q    <= 1'b0;
      dout_vld_q  <= 1'b0;
      tile_last_q <= 1'b0;
      dout_a_q    <= '0;
      dout_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wptr_q      <= wptr_d;
      rrow_q      <= rrow_d;
      rcol_q      <= rcol_d;
      wr_rdy_q    <= wr_rdy_d;
      rd_rdy_q    <= rd_rdy_d;
      rdy_sy_q    <= rdy_sy_d;
      dout_vld_q  <= dout_vld_d;
      tile_last_q <= tile_last_d;
      dout_a_q    <= dout_a_d;
      dout_b_q    <= dout_b_d;
    end
  end

  assign wr_rdy    = wr_rdy_q;
  assign rd_rdy    = rd_rdy_q;
  assign rdy_sy    = rdy_sy_q;
  assign dout_vld  = dout_vld_q;
  assign tile_last = tile_last_q;
  assign dout_a    = dout_a_q;
  assign dout_b    = dout_b_q;

endmodule

// File: tb/tb_sync_tile_buf.sv
// Self-checking bench for sync_tile_buf: tile table plus scoreboard of
// expected read-out elements, with hand sequences for handshake corners.
module tb_sync_tile_buf;

  localparam int unsigned DW = 16;
  localparam int unsigned D  = 3;
  localparam int unsigned NE = D * D;

  logic          clk = 1'b0;
  logic          rst, en, wr, rd, trans_b;
  logic [DW-1:0] din_a, din_b;
  logic          wr_rdy, rd_rdy, dout_vld, tile_last, rdy_sy;
  logic [DW-1:0] dout_a, dout_b;

  sync_tile_buf #(.DATA_W(DW), .DIM(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wr       (wr),
    .din_a    (din_a),
    .din_b    (din_b),
    .trans_b  (trans_b),
    .wr_rdy   (wr_rdy),
    .rd       (rd),
    .rd_rdy   (rd_rdy),
    .dout_a   (dout_a),
    .dout_b   (dout_b),
    .dout_vld (dout_vld),
    .tile_last(tile_last),
    .rdy_sy   (rdy_sy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          trans;
    logic [DW-1:0] a_base;
    logic [DW-1:0] b_base;
  } tile_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } exp_t;

  // Expected B read order (offsets into the written sequence) when transposed.
  int    ofs_tr [NE] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
  tile_t tiles  [7];
  exp_t  exp_q  [$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every dout_vld pulse must match the next expected element.
  always @(negedge clk) begin
    if (dout_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_dout: got a=%0h b=%0h with empty scoreboard", dout_a, dout_b);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dout_a", 32'(dout_a), 32'(e.a));
        chk("dout_b", 32'(dout_b), 32'(e.b));
        chk("tile_last", 32'(tile_last), 32'(e.last));
      end
    end
  end

  task automatic write_tile(input tile_t t, input bit pre_chk, output int stalls);
    int i = 0;
    int budget = 0;
    stalls = 0;
    while (i < int'(NE) && budget < 200) begin
      if (wr_rdy) begin
        wr      = 1'b1;
        din_a   = DW'(int'(t.a_base) + i);
        din_b   = DW'(int'(t.b_base) + i);
        trans_b = (i == 0) ? t.trans : ~t.trans;
        if (i == int'(NE) - 1) begin
          if (pre_chk) chk("rd_rdy_before_last_wr", 32'(rd_rdy), 32'd0);
          for (int j = 0; j < int'(NE); j++) begin
            exp_t e;
            e.a    = DW'(int'(t.a_base) + j);
            e.b    = DW'(int'(t.b_base) + (t.trans ? ofs_tr[j] : j));
            e.last = (j == int'(NE) - 1);
            exp_q.push_back(e);
          end
        end
        i++;
      end else begin
        wr = 1'b0;
        stalls++;
      end
      tick();
      budget++;
    end
    wr      = 1'b0;
    trans_b = 1'b0;
    if (i < int'(NE)) chk("write_timeout", 32'(i), 32'(NE));
    chk("rd_rdy_after_last_wr", 32'(rd_rdy), 32'd1);
  endtask

  task automatic read_n(input int n, output int stalls);
    int got = 0;
    int budget = 0;
    stalls = 0;
    while (got < n && budget < 200) begin
      if (rd_rdy) begin
        rd = 1'b1;
        got++;
      end else begin
        rd = 1'b0;
        stalls++;
      end
      tick();
      budget++;
    end
    rd = 1'b0;
    if (got < n) chk("read_timeout", 32'(got), 32'(n));
  endtask

  initial begin : timeout
    #1ms;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int st, st1, st2;
    tiles[0] = '{trans: 1'b0, a_base: 16'h0001, b_base: 16'h0010};
    tiles[1] = '{trans: 1'b1, a_base: 16'h0001, b_base: 16'h0010};
    tiles[2] = '{trans: 1'b1, a_base: 16'h0100, b_base: 16'h0200};
    tiles[3] = '{trans: 1'b0, a_base: 16'h0300, b_base: 16'h0400};
    tiles[4] = '{trans: 1'b1, a_base: 16'h0500, b_base: 16'h0600};
    tiles[5] = '{trans: 1'b0, a_base: 16'h0700, b_base: 16'h0800};
    tiles[6] = '{trans: 1'b1, a_base: 16'h0900, b_base: 16'h0A00};

    rst = 1'b1; en = 1'b1; wr = 1'b0; rd = 1'b0; trans_b = 1'b0;
    din_a = '0; din_b = '0;

    // Reset: all outputs low for both reset cycles.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_rdy_sy", 32'(rdy_sy), 32'd0);
      chk("rst_wr_rdy", 32'(wr_rdy), 32'd0);
      chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
      chk("rst_dout_vld", 32'(dout_vld), 32'd0);
      chk("rst_tile_last", 32'(tile_last), 32'd0);
      chk("rst_dout_a", 32'(dout_a), 32'd0);
      chk("rst_dout_b", 32'(dout_b), 32'd0);
    end

    // Start-up: en sampled at edge k, ready visible after edge k+1.
    rst = 1'b0;
    tick();
    chk("warm_rdy_sy", 32'(rdy_sy), 32'd0);
    chk("warm_wr_rdy", 32'(wr_rdy), 32'd0);
    tick();
    chk("run_rdy_sy", 32'(rdy_sy), 32'd1);
    chk("run_wr_rdy", 32'(wr_rdy), 32'd1);
    chk("run_rd_rdy", 32'(rd_rdy), 32'd0);

    // Read request with nothing available is ignored.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("ign_rd_vld", 32'(dout_vld), 32'd0);
    chk("ign_rd_dout_a", 32'(dout_a), 32'd0);

    // Straight and transposed single tiles, then idle hold of dout.
    for (int k = 0; k < 2; k++) begin
      write_tile(tiles[k], 1'b1, st);
      chk("single_wr_stall", 32'(st), 32'd0);
      read_n(int'(NE), st);
      chk("single_rd_stall", 32'(st), 32'd0);
      tick();
      chk("hold_vld", 32'(dout_vld), 32'd0);
      chk("hold_dout_a", 32'(dout_a), 32'(tiles[k].a_base + 16'd8));
      chk("hold_dout_b", 32'(dout_b), 32'(tiles[k].b_base + 16'd8));
    end

    // Ping-pong: fill tile 3 while draining tile 2, one of each per cycle.
    write_tile(tiles[2], 1'b0, st);
    fork
      write_tile(tiles[3], 1'b0, st1);
      read_n(int'(NE), st2);
    join
    chk("overlap_wr_stall", 32'(st1), 32'd0);
    chk("overlap_rd_stall", 32'(st2), 32'd0);
    chk("overlap_wr_rdy", 32'(wr_rdy), 32'd1);

    // Both banks full: writes ignored until the drained bank frees up.
    write_tile(tiles[4], 1'b0, st);
    chk("both_full_wr_rdy", 32'(wr_rdy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      wr = 1'b1; din_a = 16'hDEAD; din_b = 16'hBEEF; trans_b = 1'b1;
      tick();
      chk("full_ign_wr_rdy", 32'(wr_rdy), 32'd0);
      chk("full_ign_vld", 32'(dout_vld), 32'd0);
    end
    wr = 1'b0; trans_b = 1'b0;
    for (int k = 0; k < int'(NE); k++) begin
      chk("drain_rd_rdy", 32'(rd_rdy), 32'd1);
      rd = 1'b1;
      tick();
      chk("drain_wr_rdy", 32'(wr_rdy), 32'(k == int'(NE) - 1));
    end
    rd = 1'b0;
    read_n(int'(NE), st);
    chk("tile4_rd_stall", 32'(st), 32'd0);

    // Drain with en low, then shutdown the edge after the last read.
    write_tile(tiles[5], 1'b0, st);
    en = 1'b0;
    tick();
    chk("en_low_wr_rdy", 32'(wr_rdy), 32'd0);
    chk("en_low_rdy_sy", 32'(rdy_sy), 32'd1);
    for (int k = 0; k < int'(NE); k++) begin
      rd = 1'b1;
      tick();
      chk("en_low_drain_rdy_sy", 32'(rdy_sy), 32'd1);
    end
    rd = 1'b0;
    tick();
    chk("shutdown_rdy_sy", 32'(rdy_sy), 32'd0);
    chk("shutdown_rd_rdy", 32'(rd_rdy), 32'd0);

    // Restart, then reset in the middle of a drain.
    en = 1'b1;
    tick();
    tick();
    chk("restart_rdy_sy", 32'(rdy_sy), 32'd1);
    write_tile(tiles[6], 1'b0, st);
    en = 1'b0;
    read_n(3, st);
    rst = 1'b1;
    tick();
    chk("mid_rst_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("mid_rst_rdy_sy", 32'(rdy_sy), 32'd0);
    chk("mid_rst_vld", 32'(dout_vld), 32'd0);
    chk("mid_rst_left", 32'(exp_q.size()), 32'(NE - 3));
    exp_q.delete();
    rst = 1'b0;
    tick();
    chk("post_rst_rd_rdy", 32'(rd_rdy), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_tile_buf.md
# sync_tile_buf

Parametrised, double-buffered tile synchroniser for the GRU datapath. It captures two operand streams (A and B) as square DIM×DIM tiles and replays each completed tile. A is replayed in write order; B is replayed either in write order or transposed, selected per tile. Two ping-pong banks let the next tile fill while the previous one drains, so matrix operands from upstream reach the MAC array with a start-up handshake and no stall between tiles.

## Interface
Parameters:
- DATA_W, 16, width of each A/B element
- DIM, 3, tile dimension; tile holds N = DIM*DIM elements per channel; DIM ≥ 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  block enable; starts the block from idle and gates writes
- wr  in  1  write request; accepted when wr && wr_rdy
- din_a  in  DATA_W  channel A element
- din_b  in  DATA_W  channel B element
- trans_b  in  1  B read-order select, sampled on the first accepted write of each tile
- wr_rdy  out  1  write bank has space
- rd  in  1  read request; accepted when rd && rd_rdy
- rd_rdy  out  1  a complete tile is available for reading
- dout_a  out  DATA_W  channel A element, registered
- dout_b  out  DATA_W  channel B element, registered
- dout_vld  out  1  dout_a/dout_b updated this cycle
- tile_last  out  1  qualifies dout_vld: last element of the tile
- rdy_sy  out  1  block running

## Operation
- Control FSM:
  - IDLE → WARM when en=1.
  - WARM → RUN unconditionally (one settling cycle).
  - RUN → IDLE when en=0, both banks are empty and no fill is in progress (wptr=0).
  - rdy_sy=1 only in RUN.
- Write:
  - wr_rdy = RUN && en && !full[wbank].
  - On accept, {din_a, din_b} are stored at index wptr of wbank and wptr increments.
  - At wptr=0, trans_b is latched into tflag[wbank].
  - At wptr=N-1: full[wbank] is set, wbank toggles, wptr resets to 0.
- Read:
  - rd_rdy = RUN && full[rbank]. Reads remain allowed while en=0, so the block can drain.
  - rrow/rcol counters walk row-major.
  - dout_a = A[rbank][rrow*DIM+rcol].
  - dout_b = B[rbank][tflag ? rcol*DIM+rrow : rrow*DIM+rcol].
  - No divide/modulo is used; indices are built from the counters.
  - On the last element (rrow=rcol=DIM-1): tile_last=1, full[rbank] clears, rbank toggles, counters reset.
- Requests while the corresponding rdy is low are ignored. No error flag.
- Simultaneous write and read always target different banks (fill bank not full, drain bank full). Both proceed in the same cycle.
- A partial tile with en dropped stays in the bank. The FSM remains in RUN until the tile is completed by later writes, or until rst.
- Pointer widths: wptr is clog2(N) bits; rrow/rcol are clog2(DIM) bits. Explicit wrap at terminal counts, never natural overflow.

## Timing
- Reset values:
  - Outputs: rdy_sy, wr_rdy, rd_rdy, dout_vld, tile_last = 0; dout_a, dout_b = 0.
  - Internal: state=IDLE; full[1:0]=0; wbank=rbank=0; all pointers 0.
  - Storage arrays are not reset.
- Reset mid-operation discards all tiles on the next edge.
- en high at edge k: rdy_sy and wr_rdy are high from edge k+2.
- Final write of a tile at edge k: rd_rdy is high after edge k (visible in cycle k+1).
- Read accepted at edge k: dout_a/dout_b/dout_vld/tile_last are valid after edge k (1-cycle latency). dout holds its value when idle; dout_vld is a single-cycle pulse per read.
- Bank freed by the last read at edge k: writable (wr_rdy) from cycle k+1, never in the same cycle.
- Continuous streaming:
  - One write and one read per cycle are sustainable.
  - The first tile of a stream incurs N cycles of fill latency.

## Structure
- Package sync_pkg:
  - Defaults SYNC_DATA_W=16 and SYNC_DIM=3.
  - sync_state_t enum {IDLE, WARM, RUN}.
  - Function tr_idx(row, col, trans, dim).
- Sub-module sync_tile_bank:
  - One bank: A/B arrays of N entries, write port, combinational indexed read, stored tflag.
  - Instantiated twice. Bank select muxes and counters live in the top.

## Test plan
- Reset/start-up: rst for 2 cycles, then en=1 → rdy_sy and wr_rdy rise exactly 2 edges later; all outputs are 0 during reset.
- Straight tile: DIM=3, trans_b=0, write A=1..9, B=0x10..0x18 → rd_rdy the cycle after the 9th write; 9 reads return A=1..9, B=0x10..0x18; tile_last on the 9th.
- Transposed tile: same data with trans_b=1 → B order 0x10,0x13,0x16,0x11,0x14,0x17,0x12,0x15,0x18; A unchanged.
- Ping-pong overlap: write tile 0 (trans_b=1), then tile 1 (trans_b=0) while reading tile 0 at one read per cycle → no wr_rdy drop. Third tile: wr_rdy stays low until the cycle after tile 0's last read.
- Ignored requests: rd with rd_rdy=0, and wr when both banks are full → no state change, dout_vld=0, data unchanged.
- Drain and shutdown: en=0 with one full tile → reads still accepted; after the last read with wptr=0, rdy_sy falls next edge. rst mid-drain → rd_rdy=0 next cycle.
